// File: rtl/pipe_retire_tracker.sv
// +----------------------------------------------------------------------------+
// | pipe_retire_tracker: shadow pipeline with in-order retire record and an    |
// | optional next-PC continuity check (enabled by PIPE_TRK_PCCHK_EN). Rev 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_retire_tracker #(
  parameter int                XLEN     = 32,
  parameter int                STAGES   = 5,
  parameter logic [XLEN-1:0]   PC_INIT  = 'h200,
  parameter logic [31:0]       NOP_INSN = 32'h13,
  parameter int                ORDER_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_insn,
  input  logic [STAGES-1:0]   stall_i,
  input  logic [STAGES-1:0]   flush_i,
  input  logic                redirect_i,
  output logic [STAGES-1:0]   stg_valid_o,
  output logic                ret_valid_o,
  output logic [XLEN-1:0]     ret_pc_o,
  output logic [31:0]         ret_insn_o,
  output logic [ORDER_W-1:0]  ret_order_o,
  output logic                pc_err_o,
  output logic [XLEN-1:0]     pc_err_pc_o
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [STAGES-1:0][XLEN-1:0] stg_pc;
  logic [STAGES-1:0][31:0]     stg_insn;
  logic [STAGES-1:0]           stg_valid;
  logic                        unused_pc_lsb;

  assign unused_pc_lsb = in_pc[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            src_stall;
    logic            src_valid;
    logic [XLEN-1:0] src_pc;
    logic [31:0]     src_insn;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     insn_q, insn_d;

    if (k == 0) begin : g_head
      // A missing fetch is treated exactly like a stalled upstream stage.
      assign src_stall = ~in_valid;
      assign src_valid = 1'b1;
      assign src_pc    = {in_pc[XLEN-1:1], 1'b0};
      assign src_insn  = in_insn;
    end else begin : g_body
      assign src_stall = stall_i[k-1];
      assign src_valid = stg_valid[k-1];
      assign src_pc    = stg_pc[k-1];
      assign src_insn  = stg_insn[k-1];
    end

    always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      insn_d  = insn_q;
      if (flush_i[k]) begin
        valid_d = 1'b0;
      end else if (!stall_i[k]) begin
        if (src_stall) begin
          valid_d = 1'b0;
        end else begin
          valid_d = src_valid;
          pc_d    = src_pc;
          insn_d  = src_insn;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        pc_q    <= PC_INIT;
        insn_q  <= NOP_INSN;
      end else begin
        valid_q <= valid_d;
        pc_q    <= pc_d;
        insn_q  <= insn_d;
      end
    end

    assign stg_valid[k] = valid_q;
    assign stg_pc[k]    = pc_q;
    assign stg_insn[k]  = insn_q;
  end

  assign stg_valid_o = stg_valid;
  assign ret_valid_o = stg_valid[STAGES-1];
  assign ret_pc_o    = stg_pc[STAGES-1];
  assign ret_insn_o  = stg_insn[STAGES-1];

  logic [ORDER_W-1:0] order_q, order_d;

  always_comb begin
    order_d = order_q;
    if (ret_valid_o) order_d = order_q + ORDER_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) order_q <= '0;
    else     order_q <= order_d;
  end

  assign ret_order_o = order_q;

`ifdef PIPE_TRK_PCCHK_EN
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;
  logic            exp_vld_q, exp_vld_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] err_pc_q, err_pc_d;
  logic [XLEN-1:0] jal_imm;
  logic [XLEN-1:0] seq_step;

  assign jal_imm  = {{(XLEN-20){ret_insn_o[31]}}, ret_insn_o[19:12], ret_insn_o[20],
                     ret_insn_o[30:21], 1'b0};
  assign seq_step = (ret_insn_o[1:0] == 2'b11) ? XLEN'(4) : XLEN'(2);

  always_comb begin
    exp_pc_d  = exp_pc_q;
    exp_vld_d = exp_vld_q;
    err_d     = err_q;
    err_pc_d  = err_pc_q;
    if (ret_valid_o) begin
      if (exp_vld_q && (ret_pc_o != exp_pc_q) && !err_q) begin
        err_d    = 1'b1;
        err_pc_d = ret_pc_o;
      end
      case (ret_insn_o[6:0])
        OP_JAL: begin
          exp_pc_d  = ret_pc_o + jal_imm;
          exp_vld_d = 1'b1;
        end
        OP_JALR, OP_BRANCH: exp_vld_d = 1'b0;
        default: begin
          exp_pc_d  = ret_pc_o + seq_step;
          exp_vld_d = 1'b1;
        end
      endcase
    end
    // The retire above was already checked against the old expectation.
    if (redirect_i) exp_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pc_q  <= '0;
      exp_vld_q <= 1'b0;
      err_q     <= 1'b0;
      err_pc_q  <= '0;
    end else begin
      exp_pc_q  <= exp_pc_d;
      exp_vld_q <= exp_vld_d;
      err_q     <= err_d;
      err_pc_q  <= err_pc_d;
    end
  end

  assign pc_err_o    = err_q;
  assign pc_err_pc_o = err_pc_q;
`else
  logic unused_pcchk;
  assign unused_pcchk = redirect_i;
  assign pc_err_o     = 1'b0;
  assign pc_err_pc_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_retire_tracker.sv
// +----------------------------------------------------------------------------+
// | tb_pipe_retire_tracker: directed bench for pipe_retire_tracker. Rev 1.0    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_retire_tracker;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] JAL40 = 32'h0400_006F;
  localparam logic [31:0] CNOP  = 32'h0000_0001;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef PIPE_TRK_PCCHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, redirect_i;
  logic [31:0] in_pc, in_insn;
  logic [4:0]  stall_i, flush_i;
  logic [4:0]  stg_valid_o;
  logic        ret_valid_o, pc_err_o;
  logic [31:0] ret_pc_o, ret_insn_o, pc_err_pc_o;
  logic [3:0]  ret_order_o;

  int tests = 0;
  int fails = 0;

  pipe_retire_tracker #(
    .XLEN(32), .STAGES(5), .PC_INIT('h200), .NOP_INSN(32'h13), .ORDER_W(4)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
    .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
    .stg_valid_o(stg_valid_o), .ret_valid_o(ret_valid_o), .ret_pc_o(ret_pc_o),
    .ret_insn_o(ret_insn_o), .ret_order_o(ret_order_o), .pc_err_o(pc_err_o),
    .pc_err_pc_o(pc_err_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                     input logic [4:0] st, input logic [4:0] fl, input logic rd);
    in_valid = v; in_pc = pc; in_insn = insn;
    stall_i = st; flush_i = fl; redirect_i = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_stgv"}, {27'b0, stg_valid_o}, 32'h0);
    chk({tag, "_retv"}, {31'b0, ret_valid_o}, 32'h0);
    chk({tag, "_pc"},   ret_pc_o, 32'h200);
    chk({tag, "_insn"}, ret_insn_o, 32'h13);
    chk({tag, "_ord"},  {28'b0, ret_order_o}, 32'h0);
    chk({tag, "_err"},  {31'b0, pc_err_o}, 32'h0);
    chk({tag, "_errpc"}, pc_err_pc_o, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_insn = NOP;
    stall_i = '0; flush_i = '0; redirect_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst_init");
    rst = 1'b0;

    // Back-to-back straight-line stream
    cyc(1'b1, 32'h200, ADDI, 5'b0, 5'b0, 1'b0);
    chk("s1_stgv", {27'b0, stg_valid_o}, 32'h01);
    cyc(1'b1, 32'h204, ADDI, 5'b0, 5'b0, 1'b0);
    cyc(1'b1, 32'h208, ADDI, 5'b0, 5'b0, 1'b0);
    idle();
    chk("s1_stgv4", {27'b0, stg_valid_o}, 32'h0E);
    chk("s1_noret", {31'b0, ret_valid_o}, 32'h0);
    idle();
    chk("s1_retv0", {31'b0, ret_valid_o}, 32'h1);
    chk("s1_pc0", ret_pc_o, 32'h200);
    chk("s1_ord0", {28'b0, ret_order_o}, 32'h0);
    idle();
    chk("s1_pc1", ret_pc_o, 32'h204);
    chk("s1_ord1", {28'b0, ret_order_o}, 32'h1);
    idle();
    chk("s1_pc2", ret_pc_o, 32'h208);
    chk("s1_ord2", {28'b0, ret_order_o}, 32'h2);
    idle();
    chk("s1_retend", {31'b0, ret_valid_o}, 32'h0);
    chk("s1_err", {31'b0, pc_err_o}, 32'h0);
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);

    // Stall stages 0-1 for two cycles with three in flight
    cyc(1'b1, 32'h500, ADDI, 5'b0, 5'b0, 1'b0);
    cyc(1'b1, 32'h504, ADDI, 5'b0, 5'b0, 1'b0);
    cyc(1'b1, 32'h508, ADDI, 5'b0, 5'b0, 1'b0);
    cyc(1'b0, 32'h0, NOP, 5'b00011, 5'b0, 1'b0);
    chk("s2_stgv_a", {27'b0, stg_valid_o}, 32'h0B);
    cyc(1'b0, 32'h0, NOP, 5'b00011, 5'b0, 1'b0);
    chk("s2_stgv_b", {27'b0, stg_valid_o}, 32'h13);
    chk("s2_pc0", ret_pc_o, 32'h500);
    chk("s2_ord0", {28'b0, ret_order_o}, 32'h3);
    idle();
    chk("s2_gap1", {31'b0, ret_valid_o}, 32'h0);
    chk("s2_stgv_c", {27'b0, stg_valid_o}, 32'h06);
    idle();
    chk("s2_gap2", {31'b0, ret_valid_o}, 32'h0);
    idle();
    chk("s2_pc1", ret_pc_o, 32'h504);
    chk("s2_ord1", {28'b0, ret_order_o}, 32'h4);
    idle();
    chk("s2_pc2", ret_pc_o, 32'h508);
    chk("s2_ord2", {28'b0, ret_order_o}, 32'h5);
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);
    chk("s2_ordend", {28'b0, ret_order_o}, 32'h6);

    // Flush and stall on stage 0 in the same cycle
    cyc(1'b1, 32'h600, ADDI, 5'b0, 5'b0, 1'b0);
    chk("s3_stgv_a", {27'b0, stg_valid_o}, 32'h01);
    cyc(1'b0, 32'h0, NOP, 5'b00001, 5'b00001, 1'b0);
    chk("s3_stgv_b", {27'b0, stg_valid_o}, 32'h00);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("s3_noret", {31'b0, ret_valid_o}, 32'h0);
    end
    chk("s3_ord", {28'b0, ret_order_o}, 32'h6);

    // JAL +0x40 then the correct target after two bubbles
    cyc(1'b1, 32'h300, JAL40, 5'b0, 5'b0, 1'b0);
    idle();
    idle();
    cyc(1'b1, 32'h340, ADDI, 5'b0, 5'b0, 1'b0);
    idle();
    chk("s4a_jalpc", ret_pc_o, 32'h300);
    chk("s4a_jalinsn", ret_insn_o, JAL40);
    chk("s4a_jalord", {28'b0, ret_order_o}, 32'h6);
    idle();
    idle();
    idle();
    chk("s4a_tgtpc", ret_pc_o, 32'h340);
    chk("s4a_tgtord", {28'b0, ret_order_o}, 32'h7);
    idle();
    chk("s4a_err", {31'b0, pc_err_o}, 32'h0);
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);

    // Same JAL followed by a fall-through PC: mismatch
    cyc(1'b1, 32'h300, JAL40, 5'b0, 5'b0, 1'b0);
    idle();
    idle();
    cyc(1'b1, 32'h304, ADDI, 5'b0, 5'b0, 1'b0);
    idle();
    chk("s4b_jalord", {28'b0, ret_order_o}, 32'h8);
    idle();
    idle();
    idle();
    chk("s4b_badpc", ret_pc_o, 32'h304);
    chk("s4b_err_pre", {31'b0, pc_err_o}, 32'h0);
    idle();
    chk("s4b_err", {31'b0, pc_err_o}, {31'b0, CHK});
    chk("s4b_errpc", pc_err_pc_o, CHK ? 32'h304 : 32'h0);
    chk("s4b_ord", {28'b0, ret_order_o}, 32'hA);

    // Asynchronous reset mid-stream
    cyc(1'b1, 32'h700, ADDI, 5'b0, 5'b0, 1'b0);
    cyc(1'b1, 32'h704, ADDI, 5'b0, 5'b0, 1'b0);
    chk("s6_pre_stgv", {27'b0, stg_valid_o}, 32'h03);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    in_valid = 1'b0; in_pc = '0; in_insn = NOP;
    rst = 1'b0;

    // Compressed instruction followed by pc+2
    cyc(1'b1, 32'h400, CNOP, 5'b0, 5'b0, 1'b0);
    cyc(1'b1, 32'h402, ADDI, 5'b0, 5'b0, 1'b0);
    idle();
    idle();
    idle();
    chk("s5a_pc0", ret_pc_o, 32'h400);
    chk("s5a_ord0", {28'b0, ret_order_o}, 32'h0);
    idle();
    chk("s5a_pc1", ret_pc_o, 32'h402);
    chk("s5a_ord1", {28'b0, ret_order_o}, 32'h1);
    idle();
    chk("s5a_err", {31'b0, pc_err_o}, 32'h0);
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);

    // Compressed instruction, redirect, then an unrelated target
    cyc(1'b1, 32'h400, CNOP, 5'b0, 5'b0, 1'b0);
    idle();
    cyc(1'b1, 32'h1000, ADDI, 5'b0, 5'b0, 1'b0);
    idle();
    idle();
    chk("s5b_pc0", ret_pc_o, 32'h400);
    chk("s5b_ord0", {28'b0, ret_order_o}, 32'h2);
    idle();
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);
    chk("s5b_pc1", ret_pc_o, 32'h1000);
    chk("s5b_ord1", {28'b0, ret_order_o}, 32'h3);
    idle();
    chk("s5b_err", {31'b0, pc_err_o}, 32'h0);
    cyc(1'b0, 32'h0, NOP, 5'b0, 5'b0, 1'b1);

    // 17 back-to-back retires: order runs 4..15 then wraps to 0
    for (int j = 0; j < 21; j++) begin
      if (j < 17) cyc(1'b1, 32'h800 + 32'(4 * j), ADDI, 5'b0, 5'b0, 1'b0);
      else        idle();
      if (j >= 4) begin
        chk("wrap_pc", ret_pc_o, 32'h800 + 32'(4 * (j - 4)));
        chk("wrap_ord", {28'b0, ret_order_o}, 32'(j % 16));
      end
    end
    idle();
    chk("wrap_ordend", {28'b0, ret_order_o}, 32'h5);
    chk("wrap_err", {31'b0, pc_err_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
